// File: rtl/preadd_mac532.sv
// preadd_mac532: pipelined pre-add multiply-accumulate unit.
// Each accepted beat computes (a +/- b) * c. The products are summed over a
// group of beats that ends with in_last. Both sides use a valid/ready handshake.
// Optional build macro PREADD532_SAT_EN: on overflow the accumulator saturates
// instead of wrapping. Without it the sum wraps in two's complement.
module preadd_mac532 #(
    parameter int C_WIDTH     = 16,
    parameter int C_LATENCY   = 3,
    parameter int C_ACC_GUARD = 8,
    parameter int C_CNT_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [C_WIDTH-1:0]                     in_a,
    input  logic [C_WIDTH-1:0]                     in_b,
    input  logic [C_WIDTH-1:0]                     in_c,
    input  logic                                   in_sub,
    input  logic                                   in_last,
    input  logic                                   in_vld,
    output logic                                   in_rdy,
    output logic signed [2*C_WIDTH+2+C_ACC_GUARD-1:0] out,
    output logic [C_CNT_WIDTH-1:0]                 out_cnt,
    output logic                                   out_ovf,
    output logic                                   out_vld,
    input  logic                                   out_rdy
);

    localparam int PW = 2*C_WIDTH + 2;    // exact product width
    localparam int OW = PW + C_ACC_GUARD; // accumulator / result width
    localparam int NP = C_LATENCY - 2;    // product stage plus pure delay stages

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

    // Stage 1: operand registers
    logic               r_s1_vld, r_s1_last, r_s1_sub;
    logic [C_WIDTH-1:0] r_s1_a, r_s1_b, r_s1_c;

    // Stage 2 .. C_LATENCY-1: product and its delay line
    logic [NP-1:0]   r_p_vld, r_p_last;
    logic signed [PW-1:0] r_p_prod [NP];

    // Accumulator state for the group in progress
    logic signed [OW-1:0]   r_acc;
    logic [C_CNT_WIDTH-1:0] r_cnt;
    logic                   r_ovf;
    logic                   r_start;

    logic                   w_stall;
    logic signed [C_WIDTH+1:0] w_pre;
    logic signed [PW-1:0]   w_pre_ext, w_c_ext, w_prod;
    logic                   w_tv, w_tlast;
    logic signed [PW-1:0]   w_tprod;
    logic signed [OW-1:0]   w_base, w_sum;
    logic signed [OW:0]     w_sum_ext;
    logic                   w_ovf_now, w_ovf;
    logic [C_CNT_WIDTH-1:0] w_cnt;

    // A result waiting for a downstream accept freezes the whole pipeline.
    assign w_stall = out_vld && !out_rdy;
    assign in_rdy  = !w_stall;

    // Stage 1: capture an accepted beat, bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset along with the valids; it is cheap
            // here and keeps X out of the datapath. Only the valids gate use.
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_sub  <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_c    <= '0;
        end else if (!w_stall) begin
            // NOTE: non-blocking assignments so every stage samples the
            // pre-edge value of its predecessor.
            r_s1_vld <= in_vld;
            if (in_vld) begin
                r_s1_last <= in_last;
                r_s1_sub  <= in_sub;
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_c    <= in_c;
            end
        end
    end

    // Pre-add in C_WIDTH+2 signed bits, then exact signed product
    always_comb begin
        w_pre = r_s1_sub ? ({2'b00, r_s1_a} - {2'b00, r_s1_b})
                         : ({2'b00, r_s1_a} + {2'b00, r_s1_b});
        w_pre_ext = {{(PW-C_WIDTH-2){w_pre[C_WIDTH+1]}}, w_pre};
        w_c_ext   = {{(PW-C_WIDTH){1'b0}}, r_s1_c};
        w_prod    = w_pre_ext * w_c_ext;
    end

    // Stage 2 registers the product; later entries are pure delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_vld  <= '0;
            r_p_last <= '0;
            for (int i = 0; i < NP; i++) r_p_prod[i] <= '0;
        end else if (!w_stall) begin
            r_p_vld[0]  <= r_s1_vld;
            r_p_last[0] <= r_s1_last;
            r_p_prod[0] <= w_prod;
            for (int i = 1; i < NP; i++) begin
                r_p_vld[i]  <= r_p_vld[i-1];
                r_p_last[i] <= r_p_last[i-1];
                r_p_prod[i] <= r_p_prod[i-1];
            end
        end
    end

    assign w_tv    = r_p_vld[NP-1];
    assign w_tlast = r_p_last[NP-1];
    assign w_tprod = r_p_prod[NP-1];

    // Accumulate step: one extra bit exposes signed overflow
    always_comb begin
        w_base    = r_start ? '0 : r_acc;
        w_sum_ext = {w_base[OW-1], w_base} + {{(OW+1-PW){w_tprod[PW-1]}}, w_tprod};
        w_ovf_now = w_sum_ext[OW] ^ w_sum_ext[OW-1];
        w_ovf     = (!r_start && r_ovf) || w_ovf_now;
`ifdef PREADD532_SAT_EN
        // Once clamped, the group stays at its clamp value.
        if (!r_start && r_ovf)
            w_sum = r_acc;
        else if (w_ovf_now)
            w_sum = w_sum_ext[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            w_sum = w_sum_ext[OW-1:0];
`else
        w_sum = w_sum_ext[OW-1:0];
`endif
        w_cnt = r_start ? CNT_ONE : ((&r_cnt) ? r_cnt : r_cnt + CNT_ONE);
    end

    // Accumulate/output stage: fold beats in, publish the sum on a last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_start <= 1'b1;
            out     <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
            out_vld <= 1'b0;
        end else if (!w_stall) begin
            out_vld <= w_tv && w_tlast;
            if (w_tv) begin
                if (w_tlast) begin
                    out     <= w_sum;
                    out_cnt <= w_cnt;
                    out_ovf <= w_ovf;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                    r_start <= 1'b1;
                end else begin
                    r_acc   <= w_sum;
                    r_cnt   <= w_cnt;
                    r_ovf   <= w_ovf;
                    r_start <= 1'b0;
                end
            end
        end
    end

endmodule
